// File: rtl/pipeline_types_pkg.sv
// pipeline_types_pkg: shared types and constants for the pipeline latch set.
//   pstage_op_t         - per-register operation chosen each edge
//   PIPE_STAGES_DEFAULT - default number of inter-stage registers
package pipeline_types_pkg;

  localparam int unsigned PIPE_STAGES_DEFAULT = 4;

  // BUBBLE and CLEAR produce the same register value; they are kept distinct
  // so the source of an empty slot (stall vs flush) stays visible in waves.
  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    HOLD   = 2'd1,
    BUBBLE = 2'd2,
    CLEAR  = 2'd3
  } pstage_op_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one inter-stage register (DATA_W payload plus valid bit).
// Ports:
//   CLK, RST     - clock, synchronous active-high reset
//   op_i         - LOAD / HOLD / BUBBLE / CLEAR for this edge
//   src_data_i   - payload loaded on LOAD
//   src_valid_i  - valid loaded on LOAD
//   data_o       - registered payload
//   valid_o      - registered valid
module pipe_stage_reg
  import pipeline_types_pkg::*;
#(
  parameter int unsigned DATA_W = 256
) (
  input  logic              CLK,
  input  logic              RST,
  input  pstage_op_t        op_i,
  input  logic [DATA_W-1:0] src_data_i,
  input  logic              src_valid_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_d, data_q;
  logic              valid_d, valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    unique case (op_i)
      LOAD: begin
        data_d  = src_data_i;
        valid_d = src_valid_i;
      end
      HOLD: begin
        data_d  = data_q;
        valid_d = valid_q;
      end
      BUBBLE, CLEAR: begin
        data_d  = '0;
        valid_d = 1'b0;
      end
      default: begin
        data_d  = data_q;
        valid_d = valid_q;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipeline_stage_array.sv
// pipeline_stage_array: NSTAGES inter-stage registers with load/hold/bubble/clear
// control from a global advance qualifier, global freeze, and per-register
// stall and flush vectors. Register 0 is nearest fetch.
// Ports:
//   CLK, RST          - clock, synchronous active-high reset
//   advance           - memory-hit qualifier; nothing moves while low
//   freeze            - hold every register
//   stall[i]          - bubble into register i, hold registers below i
//   flush[i]          - clear register i this edge (beats everything but RST)
//   in_data/in_valid  - source for register 0
//   stage_data/valid  - registered contents of every register
//   perf_clr          - zero the performance counters
//   perf_*_cnt        - saturating advance / stall / flush counters
// Build option: define PIPE_PERF_EN to build the counters; otherwise the
// counter outputs are tied to 0 and perf_clr is ignored.
module pipeline_stage_array
  import pipeline_types_pkg::*;
#(
  parameter int unsigned NSTAGES = PIPE_STAGES_DEFAULT,
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            advance,
  input  logic                            freeze,
  input  logic [NSTAGES-1:0]              stall,
  input  logic [NSTAGES-1:0]              flush,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            in_valid,
  output logic [NSTAGES-1:0][DATA_W-1:0]  stage_data,
  output logic [NSTAGES-1:0]              stage_valid,
  input  logic                            perf_clr,
  output logic [CNT_W-1:0]                perf_adv_cnt,
  output logic [CNT_W-1:0]                perf_stall_cnt,
  output logic [CNT_W-1:0]                perf_flush_cnt
);

  localparam int unsigned IdxW = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;

  logic                           moving;
  logic                           stall_any;
  logic [IdxW-1:0]                stall_idx;
  pstage_op_t                     op [NSTAGES];
  logic [NSTAGES-1:0][DATA_W-1:0] src_data;
  logic [NSTAGES-1:0]             src_valid;

  assign moving    = advance & ~freeze;
  assign stall_any = |stall;

  // Priority encoder: highest set stall bit wins, lower ones are subsumed.
  always_comb begin
    stall_idx = '0;
    for (int i = 0; i < int'(NSTAGES); i++) begin
      if (stall[i]) stall_idx = IdxW'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NSTAGES); i++) begin
      op[i] = LOAD;
      if (flush[i]) begin
        op[i] = CLEAR;
      end else if (!moving) begin
        op[i] = HOLD;
      end else if (stall_any && (IdxW'(i) == stall_idx)) begin
        op[i] = BUBBLE;
      end else if (stall_any && (IdxW'(i) < stall_idx)) begin
        op[i] = HOLD;
      end else begin
        op[i] = LOAD;
      end
    end
  end

  for (genvar g = 0; g < NSTAGES; g++) begin : g_stage
    if (g == 0) begin : g_src_in
      assign src_data[g]  = in_data;
      assign src_valid[g] = in_valid;
    end else begin : g_src_prev
      assign src_data[g]  = stage_data[g-1];
      assign src_valid[g] = stage_valid[g-1];
    end

    pipe_stage_reg #(
      .DATA_W (DATA_W)
    ) u_reg (
      .CLK         (CLK),
      .RST         (RST),
      .op_i        (op[g]),
      .src_data_i  (src_data[g]),
      .src_valid_i (src_valid[g]),
      .data_o      (stage_data[g]),
      .valid_o     (stage_valid[g])
    );
  end

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] adv_cnt_q, stall_cnt_q, flush_cnt_q;

  // perf_clr shares the reset branch so it overrides any same-cycle increment.
  always_ff @(posedge CLK) begin
    if (RST || perf_clr) begin
      adv_cnt_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (moving && (adv_cnt_q != '1)) adv_cnt_q <= adv_cnt_q + 1'b1;
      if (moving && stall_any && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if ((|flush) && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign perf_adv_cnt   = adv_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;

  assign perf_adv_cnt   = '0;
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: doc/pipeline_stage_array.md
# pipeline_stage_array

Parametrised, generate-built replacement for the fixed four-register pipeline latch set. It holds NSTAGES inter-stage registers of DATA_W bits plus a valid bit each, and computes load / hold / bubble / clear per register from one global advance qualifier, a global freeze, and per-register stall and flush vectors. It sits between the per-stage datapath logic and the hazard unit in the pipelined and multicore datapaths. Optional saturating performance counters report advance, stall and flush activity.

## Interface
Parameters:
- NSTAGES, 4, number of inter-stage registers (min 2); register 0 is nearest fetch.
- DATA_W, 256, payload width per register (packed stage struct width).
- CNT_W, 32, performance counter width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous and active-high.
- advance  in  1  memory-hit qualifier (ihit|dhit); nothing moves while low.
- freeze  in  1  hold every register (all-stall).
- stall  in  NSTAGES  stall[i]: bubble into register i, hold registers below i.
- flush  in  NSTAGES  flush[i]: clear register i this edge.
- in_data  in  DATA_W  payload into register 0.
- in_valid  in  1  valid into register 0.
- stage_data  out  NSTAGES x DATA_W  register contents.
- stage_valid  out  NSTAGES  register valid bits.
- perf_clr  in  1  clear performance counters.
- perf_adv_cnt / perf_stall_cnt / perf_flush_cnt  out  CNT_W each  performance counters.

## Operation
- Register i source: in_data/in_valid for i=0, else register i-1.
- Moving cycle: advance=1 and freeze=0.
- Not moving: every register holds; stall ignored.
- Moving, stall==0: every register loads its source.
- Moving, stall!=0: s = highest set index of stall. Registers 0..s-1 hold. Register s takes a bubble (data 0, valid 0). Registers s+1..NSTAGES-1 load their sources. Lower set stall bits are subsumed.
- Flush: flush[i]=1 clears register i to data 0, valid 0 on the edge, regardless of advance, freeze or stall. Flush has highest priority after RST.
- Priority per register: RST > flush[i] > not moving (hold) > bubble > hold-below-stall > load.
- Bubble and clear are identical: all-zero payload, valid 0.

## Timing
- RST=1 at an edge: all stage_data 0, all stage_valid 0, all counters 0. This holds mid-operation; any in-flight contents are discarded.
- Latency: 1 cycle per register. A value presented with a moving cycle at edge k appears at stage_data[0] after edge k. With stall==0 and advance held high, it reaches register j after edge k+j.
- Outputs are registered only; there is no combinational path from inputs to outputs.
- Same-cycle stall[s] and flush[s]: register s is cleared, which gives the same value as a bubble. Registers below s still hold.
- flush[i] with freeze=1: register i clears and all other registers hold.

## Configuration
- PIPE_PERF_EN defined:
  - perf_adv_cnt increments on each moving cycle.
  - perf_stall_cnt increments on each moving cycle with stall!=0.
  - perf_flush_cnt increments on each cycle with flush!=0.
  - All three saturate at 2^CNT_W-1.
  - perf_clr zeroes all three on the edge and overrides any increment that cycle.
- PIPE_PERF_EN undefined: counter outputs are constant 0, perf_clr is ignored, and no counter flops are synthesised. Ports are present in both builds.

## Structure
- pipeline_types_pkg gains:
  - pstage_op_t enum: LOAD, HOLD, BUBBLE, CLEAR.
  - constant PIPE_STAGES_DEFAULT=4.
- Sub-module pipe_stage_reg: one DATA_W+1 register taking a pstage_op_t, a source payload/valid, CLK and RST. It is instantiated NSTAGES times via generate.
- Top level contains:
  - a priority encoder for s;
  - per-register op derivation;
  - the ifdef-guarded counter block.

## Test plan
- Reset/fill: RST 1 cycle, then advance=1 with in_data=0xA,0xB,0xC,0xD, in_valid=1 -> after 4 edges stage_data = {D,C,B,A} for registers 0..3, all valid.
- Gate: from the filled state, advance=0 for 3 cycles with new in_data=0xE -> contents unchanged. Set advance=1 -> register 0=E and the rest shift by one.
- Stall: filled {1,2,3,4}, stall=4'b0100 (s=2), in_data=5, one moving cycle -> reg0=1, reg1=2, reg2=bubble (0, valid 0), reg3=3.
- Multi-stall plus flush: stall=4'b0011 with flush=4'b1000, in_data=9 -> reg0 holds, reg1 bubble, reg2 loads old reg1, reg3 cleared. Repeat with freeze=1 -> only reg3 clears.
- Mid-operation reset: assert RST while stall=1 and flush!=0 -> next edge all zero, counters 0.
- PIPE_PERF_EN:
  - 10 moving cycles with 3 of them stalled and 2 flush cycles -> adv=10, stall=3, flush=2.
  - Then perf_clr coinciding with a moving cycle -> all counters 0.
  - With CNT_W=2, 5 moving cycles -> perf_adv_cnt saturates at 3.
  - Built without the macro, the same stimulus -> counters read 0.
